// File: rtl/univ_shift_reg_pkg.sv
// Shared definitions for the universal shift register.
// Holds the opcode width and opcode values carried on the command bus,
// plus the XFER control state encoding.
package shift_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_NOP  = 3'd0;
    localparam logic [OP_W-1:0] OP_LOAD = 3'd1;
    localparam logic [OP_W-1:0] OP_CLR  = 3'd2;
    localparam logic [OP_W-1:0] OP_SHL  = 3'd3;
    localparam logic [OP_W-1:0] OP_SHR  = 3'd4;
    localparam logic [OP_W-1:0] OP_ROL  = 3'd5;
    localparam logic [OP_W-1:0] OP_ROR  = 3'd6;
    localparam logic [OP_W-1:0] OP_XFER = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/univ_shift_reg_if.sv
// Command channel of the universal shift register.
// Signals:
//   cmd_valid  source offers a command
//   cmd_ready  register can take a command this cycle
//   cmd_op     opcode (see shift_pkg)
//   cmd_data   parallel word used by LOAD and XFER
// Modports: master = command source, slave = shift register.
interface univ_shift_reg_if
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
);

    logic             cmd_valid;
    logic             cmd_ready;
    logic [OP_W-1:0]  cmd_op;
    logic [WIDTH-1:0] cmd_data;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_data,
        output cmd_ready
    );

endinterface

// File: rtl/univ_shift_reg.sv
// Universal shift register with a command handshake.
// Executes hold/load/clear/shift/rotate in one cycle, and a counted XFER
// burst that shifts a word out MSB-first while capturing one from sin.
// Ports:
//   clk    clock, rising edge
//   reset  synchronous active-high reset, overrides everything
//   en     clock enable for command acceptance and burst shifting
//   sin    serial input
//   cmd    command channel (slave side)
//   pout   register contents
//   sout   last bit shifted or rotated out
//   busy   burst in progress (SHIFT or DONE)
//   done   one-cycle pulse when a burst completes
module univ_shift_reg
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             sin,
    univ_shift_reg_if.slave  cmd,
    output logic [WIDTH-1:0] pout,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0] pout_nxt;
    logic             sout_nxt;
    logic             accept;

    // Status decodes straight from the state register, so they change only on edges.
    assign busy          = (state != ST_IDLE);
    assign done          = (state == ST_DONE);
    assign cmd.cmd_ready = ~busy;
    assign accept        = cmd.cmd_valid & cmd.cmd_ready & en;

    // Burst sequencing: the counter is loaded with WIDTH and the shift that
    // consumes the last bit (counter at 1) moves on to DONE.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (accept && cmd.cmd_op == OP_XFER) begin
                    state_nxt = ST_SHIFT;
                    cnt_nxt   = CNT_W'(WIDTH);
                end
            end
            ST_SHIFT: begin
                if (en) begin
                    cnt_nxt = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Datapath: single-cycle ops act only on the accept edge in IDLE; during
    // a burst every enabled edge is a left shift fed from sin.
    always_comb begin
        pout_nxt = pout;
        sout_nxt = sout;
        if (state == ST_IDLE && accept) begin
            case (cmd.cmd_op)
                OP_LOAD: pout_nxt = cmd.cmd_data;
                OP_CLR: begin
                    pout_nxt = '0;
                    sout_nxt = 1'b0;
                end
                OP_SHL: begin
                    pout_nxt = {pout[WIDTH-2:0], sin};
                    sout_nxt = pout[WIDTH-1];
                end
                OP_SHR: begin
                    pout_nxt = {sin, pout[WIDTH-1:1]};
                    sout_nxt = pout[0];
                end
                OP_ROL: begin
                    pout_nxt = {pout[WIDTH-2:0], pout[WIDTH-1]};
                    sout_nxt = pout[WIDTH-1];
                end
                OP_ROR: begin
                    pout_nxt = {pout[0], pout[WIDTH-1:1]};
                    sout_nxt = pout[0];
                end
                OP_XFER: pout_nxt = cmd.cmd_data;
                default: ;
            endcase
        end else if (state == ST_SHIFT && en) begin
            pout_nxt = {pout[WIDTH-2:0], sin};
            sout_nxt = pout[WIDTH-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pout <= '0;
            sout <= 1'b0;
        end else begin
            pout <= pout_nxt;
            sout <= sout_nxt;
        end
    end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH = 8).
// Expected values come from arithmetic on the opcode rules: single ops are
// modelled as integer multiply/divide/modulo on the register value, bursts
// by closed-form formulas for the contents after each shift edge.
module tb_univ_shift_reg;

    import shift_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic         sin;
    logic [W-1:0] pout;
    logic         sout;
    logic         busy;
    logic         done;

    int checks   = 0;
    int failures = 0;

    univ_shift_reg_if #(.WIDTH(W)) bus ();

    univ_shift_reg #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .sin   (sin),
        .cmd   (bus.slave),
        .pout  (pout),
        .sout  (sout),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference for single-cycle ops: returns {sout, pout}.
    function automatic logic [8:0] ref_op(input int op, input int p, input int so,
                                         input int data, input int s);
        int np;
        int ns;
        np = p;
        ns = so;
        case (op)
            1: np = data;
            2: begin np = 0; ns = 0; end
            3: begin np = (p * 2 + s) % 256;       ns = p / 128; end
            4: begin np = s * 128 + p / 2;         ns = p % 2;   end
            5: begin np = (p * 2) % 256 + p / 128; ns = p / 128; end
            6: begin np = (p % 2) * 128 + p / 2;   ns = p % 2;   end
            default: ;
        endcase
        return {ns[0], np[7:0]};
    endfunction

    // Burst contents after k shift edges: remaining data bits on top, captured sin bits below.
    function automatic logic [7:0] ref_xfer_pout(input int data, input int word, input int k);
        int v;
        v = ((data * (1 << k)) + (word / (1 << (8 - k)))) % 256;
        return v[7:0];
    endfunction

    function automatic logic ref_xfer_sout(input int data, input int k);
        return ((data / (1 << (8 - k))) % 2) == 1;
    endfunction

    task automatic test_reset();
        reset         = 1'b1;
        en            = 1'b1;
        sin           = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OP_NOP;
        bus.cmd_data  = '0;
        tick();
        tick();
        checks++; if (pout !== 8'h00) begin failures++; $display("[TB] FAIL reset_pout got=%h exp=00", pout); end
        checks++; if (sout !== 1'b0) begin failures++; $display("[TB] FAIL reset_sout got=%b exp=0", sout); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%b exp=0", done); end
        checks++; if (bus.cmd_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready got=%b exp=1", bus.cmd_ready); end
        reset = 1'b0;
    endtask

    task automatic test_single_ops();
        logic [2:0] ops   [6] = '{OP_LOAD, OP_SHL, OP_SHR, OP_LOAD, OP_ROL, OP_ROR};
        logic [7:0] dats  [6] = '{8'hA5, 8'h00, 8'h00, 8'h81, 8'h00, 8'h00};
        logic       sins  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [7:0] epout [6] = '{8'hA5, 8'h4B, 8'h25, 8'h81, 8'h03, 8'h81};
        logic       esout [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_op    = ops[i];
            bus.cmd_data  = dats[i];
            sin           = sins[i];
            tick();
            checks++; if (pout !== epout[i]) begin failures++; $display("[TB] FAIL dir_pout[%0d] got=%h exp=%h", i, pout, epout[i]); end
            checks++; if (sout !== esout[i]) begin failures++; $display("[TB] FAIL dir_sout[%0d] got=%b exp=%b", i, sout, esout[i]); end
            checks++; if (bus.cmd_ready !== 1'b1) begin failures++; $display("[TB] FAIL dir_ready[%0d] got=%b exp=1", i, bus.cmd_ready); end
        end
        bus.cmd_valid = 1'b0;
    endtask

    task automatic test_random_ops();
        int          p;
        int          so;
        int          op;
        logic [8:0]  r;
        logic        v;
        logic        e;
        p  = int'(pout);
        so = int'(sout);
        for (int i = 0; i < 60; i++) begin
            op = int'($urandom_range(0, 6));
            v  = 1'($urandom_range(0, 3) != 0);
            e  = 1'($urandom_range(0, 3) != 0);
            bus.cmd_valid = v;
            bus.cmd_op    = 3'(op);
            bus.cmd_data  = 8'($urandom);
            sin           = 1'($urandom);
            en            = e;
            if (v && e) begin
                r  = ref_op(op, p, so, int'(bus.cmd_data), int'(sin));
                p  = int'(r[7:0]);
                so = int'(r[8]);
            end
            tick();
            checks++; if (pout !== 8'(p)) begin failures++; $display("[TB] FAIL rnd_pout[%0d] op=%0d v=%b en=%b got=%h exp=%h", i, op, v, e, pout, 8'(p)); end
            checks++; if (sout !== 1'(so)) begin failures++; $display("[TB] FAIL rnd_sout[%0d] op=%0d got=%b exp=%b", i, op, sout, 1'(so)); end
            checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rnd_busy[%0d] got=%b exp=0", i, busy); end
        end
        bus.cmd_valid = 1'b0;
        en            = 1'b1;
    endtask

    // One burst with an optional stall of stall_len edges inserted after edge stall_at (1..7);
    // a LOAD of ld is held valid throughout and must land only after the DONE cycle.
    task automatic test_xfer(input logic [7:0] data, input logic [7:0] word,
                             input int stall_at, input int stall_len, input logic [7:0] ld);
        en            = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_XFER;
        bus.cmd_data  = data;
        tick();
        checks++; if (pout !== data) begin failures++; $display("[TB] FAIL xfer_load got=%h exp=%h", pout, data); end
        checks++; if (busy !== 1'b1 || bus.cmd_ready !== 1'b0) begin failures++; $display("[TB] FAIL xfer_busy got=%b/%b exp=1/0", busy, bus.cmd_ready); end
        bus.cmd_op   = OP_LOAD;
        bus.cmd_data = ld;
        for (int k = 1; k <= 8; k++) begin
            if (stall_len > 0 && k == stall_at + 1) begin
                for (int s = 0; s < stall_len; s++) begin
                    en  = 1'b0;
                    sin = 1'($urandom);
                    tick();
                    checks++; if (pout !== ref_xfer_pout(data, word, k - 1)) begin failures++; $display("[TB] FAIL stall_pout k=%0d got=%h exp=%h", k, pout, ref_xfer_pout(data, word, k - 1)); end
                    checks++; if (sout !== ref_xfer_sout(data, k - 1)) begin failures++; $display("[TB] FAIL stall_sout k=%0d got=%b exp=%b", k, sout, ref_xfer_sout(data, k - 1)); end
                    checks++; if (done !== 1'b0 || busy !== 1'b1) begin failures++; $display("[TB] FAIL stall_state k=%0d done=%b busy=%b exp=0/1", k, done, busy); end
                end
                en = 1'b1;
            end
            sin = word[8-k];
            tick();
            checks++; if (sout !== ref_xfer_sout(data, k)) begin failures++; $display("[TB] FAIL xfer_sout k=%0d got=%b exp=%b", k, sout, ref_xfer_sout(data, k)); end
            checks++; if (pout !== ref_xfer_pout(data, word, k)) begin failures++; $display("[TB] FAIL xfer_pout k=%0d got=%h exp=%h", k, pout, ref_xfer_pout(data, word, k)); end
            checks++; if (done !== (k == 8)) begin failures++; $display("[TB] FAIL xfer_done k=%0d got=%b exp=%b", k, done, (k == 8)); end
        end
        checks++; if (bus.cmd_ready !== 1'b0) begin failures++; $display("[TB] FAIL done_ready got=%b exp=0", bus.cmd_ready); end
        tick();
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL end_state done=%b busy=%b exp=0/0", done, busy); end
        checks++; if (bus.cmd_ready !== 1'b1) begin failures++; $display("[TB] FAIL end_ready got=%b exp=1", bus.cmd_ready); end
        checks++; if (pout !== word) begin failures++; $display("[TB] FAIL held_load_early got=%h exp=%h", pout, word); end
        tick();
        checks++; if (pout !== ld) begin failures++; $display("[TB] FAIL held_load got=%h exp=%h", pout, ld); end
        bus.cmd_valid = 1'b0;
    endtask

    task automatic test_reset_mid_xfer();
        logic saw_done;
        saw_done      = 1'b0;
        en            = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_XFER;
        bus.cmd_data  = 8'hC3;
        tick();
        bus.cmd_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            sin = 1'((8'h5A >> (8 - k)) & 8'h01);
            tick();
            saw_done = saw_done | done;
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (pout !== 8'h00 || sout !== 1'b0) begin failures++; $display("[TB] FAIL abort_regs pout=%h sout=%b exp=00/0", pout, sout); end
        checks++; if (busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin failures++; $display("[TB] FAIL abort_state busy=%b ready=%b exp=0/1", busy, bus.cmd_ready); end
        saw_done = saw_done | done;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_LOAD;
        bus.cmd_data  = 8'h3C;
        tick();
        bus.cmd_valid = 1'b0;
        saw_done = saw_done | done;
        checks++; if (pout !== 8'h3C) begin failures++; $display("[TB] FAIL abort_load got=%h exp=3c", pout); end
        for (int i = 0; i < 3; i++) begin
            tick();
            saw_done = saw_done | done;
        end
        checks++; if (saw_done !== 1'b0) begin failures++; $display("[TB] FAIL abort_done got=%b exp=0", saw_done); end
    endtask

    initial begin
        test_reset();
        test_single_ops();
        test_random_ops();
        test_xfer(8'hC3, 8'h5A, 0, 0, 8'h96);
        test_xfer(8'hC3, 8'h5A, 4, 3, 8'h69);
        for (int i = 0; i < 4; i++) begin
            test_xfer(8'($urandom), 8'($urandom), int'($urandom_range(1, 7)),
                      int'($urandom_range(0, 3)), 8'($urandom));
        end
        test_reset_mid_xfer();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
Parametrised universal shift register that succeeds the fixed serial-in/serial-out delay line. Accepts single-cycle commands over a valid/ready handshake: hold, load, clear, shift and rotate in either direction. A counted XFER burst shifts a parallel word out MSB-first while capturing a new word from the serial input. It serves as the shift engine for serial links (SPI-style masters, serialisers) and as a general-purpose register in datapaths.

Parameters:
WIDTH, 8, register width in bits; legal range WIDTH >= 2
CNT_W, $clog2(WIDTH+1), width of the internal XFER bit counter; derived, not overridden

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high; clears all state
en  input  1  clock enable; gates command acceptance and shifting
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept a command; equals (state==IDLE)
cmd_op  input  3  opcode: 0 NOP, 1 LOAD, 2 CLR, 3 SHL, 4 SHR, 5 ROL, 6 ROR, 7 XFER
cmd_data  input  WIDTH  parallel data for LOAD/XFER
sin  input  1  serial input
pout  output  WIDTH  register contents (registered)
sout  output  1  last bit shifted/rotated out (registered)
busy  output  1  high in SHIFT and DONE states
done  output  1  one-cycle pulse at XFER completion (registered, high in DONE)

Behaviour:
- Reset (synchronous, active-high; clock clk): state=IDLE, pout=0, sout=0, done=0, busy=0, counter=0. Reset has priority over en and any command, including mid-XFER.
- Accept = cmd_valid & cmd_ready & en. Commands offered while not ready are neither accepted nor lost; the source holds them.
- Single-cycle ops (executed on the accept edge; state stays IDLE):
  - NOP: no change.
  - LOAD: pout<=cmd_data; sout unchanged.
  - CLR: pout<=0; sout<=0.
  - SHL: pout<={pout[W-2:0],sin}; sout<=pout[W-1].
  - SHR: pout<={sin,pout[W-1:1]}; sout<=pout[0].
  - ROL: pout<={pout[W-2:0],pout[W-1]}; sout<=pout[W-1].
  - ROR: pout<={pout[0],pout[W-1:1]}; sout<=pout[0].
- XFER FSM, with states IDLE, SHIFT and DONE:
  - Accept edge (edge 0): pout<=cmd_data, counter<=WIDTH, go to SHIFT.
  - SHIFT: on each edge with en=1, pout<={pout[W-2:0],sin}, sout<=pout[W-1], counter<=counter-1. The shift on which counter==1 moves the FSM to DONE.
  - SHIFT with en=0: pout, sout and counter hold.
  - DONE: done=1 for exactly one cycle, then go to IDLE on the next edge regardless of en.
- XFER timing with no stalls:
  - After edge k (1..WIDTH), sout = cmd_data[WIDTH-k].
  - sin sampled at edge k lands in pout bit WIDTH-k after edge WIDTH, so the first sin bit becomes the MSB.
  - done is high in the cycle after edge WIDTH; cmd_ready returns after edge WIDTH+1.
  - Each en=0 cycle during SHIFT adds one cycle to this latency.
- busy = (state!=IDLE); cmd_ready = ~busy (combinational from state).
- Reset during SHIFT or DONE: the burst aborts, no done pulse, and a command is accepted the cycle after reset deasserts.

Decomposition:
- Package shift_pkg: opcode localparams (OP_NOP..OP_XFER), state encoding (ST_IDLE, ST_SHIFT, ST_DONE), 3-bit opcode width constant.
- Single module; no sub-module needed. The datapath next-value mux and the FSM/counter are separate always blocks in the same file.

Test Plan:
- Reset asserted 2 cycles -> pout=0x00, sout=0, busy=0, done=0, cmd_ready=1.
- LOAD 0xA5; SHL sin=1; SHR sin=0 -> pout 0xA5, then 0x4B with sout=1, then 0x25 with sout=1; each op completes in one cycle with cmd_ready held high.
- LOAD 0x81; ROL; ROR -> pout 0x03 with sout=1, then 0x81 with sout=1.
- XFER cmd_data=0xC3, sin driven with 0x5A MSB-first on edges 1..8 -> sout sequence 1,1,0,0,0,0,1,1; pout=0x5A after edge 8; done high one cycle after edge 8; a LOAD held valid during busy is accepted only after edge 9.
- Same XFER with en=0 for 3 cycles after edge 4 -> pout, sout and counter frozen during the stall; done delayed exactly 3 cycles; final pout=0x5A.
- reset pulsed after edge 5 of XFER -> next cycle IDLE, pout=0, sout=0, done never pulses; a LOAD 0x3C is accepted the following cycle and gives pout=0x3C.
